// File: rtl/adr_rcla.sv
// rtl/adr_rcla.sv - registered ripple-carry-lookahead adder
//
// Adds two unsigned WIDTH-bit operands plus a carry-in. The sum, carry-out
// and two's-complement overflow are registered on the rising edge of clk.
// Carries are resolved by flat sum-of-products lookahead inside 4-bit
// groups. Group carries ripple from one group to the next, so the critical
// path grows with ceil(WIDTH/4) rather than with WIDTH.
//
// Parameters:
//   WIDTH  operand/sum width, 1..64 (default 3)
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   x, y   in   WIDTH-bit unsigned operands
//   cin    in   carry-in (weight 1)
//   sum    out  registered sum [WIDTH-1:0]
//   cout   out  registered carry-out (weight 2^WIDTH)
//   ovf    out  registered two's-complement overflow, c[WIDTH] ^ c[WIDTH-1]
//   gp     out  (ADR_RCLA_PG_OUT_EN only) registered whole-word propagate
//   gg     out  (ADR_RCLA_PG_OUT_EN only) registered whole-word generate
//
// Optional feature macro: ADR_RCLA_PG_OUT_EN

module adr_rcla #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef ADR_RCLA_PG_OUT_EN
    ,
    output logic             gp,
    output logic             gg
`endif
);

    localparam int NG = (WIDTH + 3) / 4;
    localparam int XW = NG * 4;

    // Carry into position k (1..3) of a 4-bit group, written as a flat
    // sum-of-products of the group's g/p terms and the group carry-in.
    // The loops fully unroll; no term depends on another bit's carry.
    function automatic logic f_carry(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       cg,
        input int         k
    );
        logic r;
        logic t;
        r = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j < k) begin
                t = g[j];
                for (int m = 0; m < 4; m++) begin
                    if (m > j && m < k) begin
                        t = t & p[m];
                    end
                end
                r = r | t;
            end
        end
        t = cg;
        for (int m = 0; m < 4; m++) begin
            if (m < k) begin
                t = t & p[m];
            end
        end
        return r | t;
    endfunction

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
`ifdef ADR_RCLA_PG_OUT_EN
    logic             w_gp;
    logic             w_gg;
`endif

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
`ifdef ADR_RCLA_PG_OUT_EN
    logic             r_gp;
    logic             r_gg;
`endif

    assign w_p = x ^ y;
    assign w_g = x & y;

    always_comb begin
        logic [XW-1:0] gx;
        logic [XW-1:0] px;
        logic [XW:0]   cx;
        logic [3:0]    g4;
        logic [3:0]    p4;
        logic          grp_g;
        logic          grp_p;
        logic          cg;
`ifdef ADR_RCLA_PG_OUT_EN
        logic          gg_acc;
        gg_acc = 1'b0;
`endif
        // Pad beyond WIDTH with g=0, p=1: lanes above the top bit just pass
        // c[WIDTH] upward, so the real carries and the last group's
        // propagate term are unaffected by the partial group.
        gx = '0;
        px = '1;
        gx[WIDTH-1:0] = w_g;
        px[WIDTH-1:0] = w_p;
        cx = '0;
        cx[0] = cin;
        for (int grp = 0; grp < NG; grp++) begin
            g4    = gx[grp*4 +: 4];
            p4    = px[grp*4 +: 4];
            cg    = cx[grp*4];
            grp_g = f_carry(g4, p4, 1'b0, 4);
            grp_p = &p4;
            for (int k = 1; k < 4; k++) begin
                cx[grp*4 + k] = f_carry(g4, p4, cg, k);
            end
            // Ripple between groups: group carry-out = GG | GP & cgin.
            cx[grp*4 + 4] = grp_g | (grp_p & cg);
`ifdef ADR_RCLA_PG_OUT_EN
            gg_acc = grp_g | (grp_p & gg_acc);
`endif
        end
        w_c = cx[WIDTH:0];
`ifdef ADR_RCLA_PG_OUT_EN
        w_gg = gg_acc;
        w_gp = &px;
`endif
    end

    assign w_sum  = w_p ^ w_c[WIDTH-1:0];
    assign w_cout = w_c[WIDTH];
    assign w_ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
`ifdef ADR_RCLA_PG_OUT_EN
            r_gp   <= 1'b0;
            r_gg   <= 1'b0;
`endif
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
`ifdef ADR_RCLA_PG_OUT_EN
            r_gp   <= w_gp;
            r_gg   <= w_gg;
`endif
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
`ifdef ADR_RCLA_PG_OUT_EN
    assign gp   = r_gp;
    assign gg   = r_gg;
`endif

endmodule

// File: tb/tb_adr_rcla.sv
// tb/tb_adr_rcla.sv - directed self-checking bench for adr_rcla (WIDTH 3 and 9)

module tb_adr_rcla;

    logic       clk;
    logic       rst_n;
    logic [2:0] x3;
    logic [2:0] y3;
    logic       cin3;
    logic [2:0] sum3;
    logic       cout3;
    logic       ovf3;
    logic [8:0] x9;
    logic [8:0] y9;
    logic       cin9;
    logic [8:0] sum9;
    logic       cout9;
    logic       ovf9;
`ifdef ADR_RCLA_PG_OUT_EN
    logic       gp9;
    logic       gg9;
    logic       gp3;
    logic       gg3;
`endif

    int total;
    int bad;

    adr_rcla #(.WIDTH(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x3),
        .y     (y3),
        .cin   (cin3),
        .sum   (sum3),
        .cout  (cout3),
        .ovf   (ovf3)
`ifdef ADR_RCLA_PG_OUT_EN
        ,
        .gp    (gp3),
        .gg    (gg3)
`endif
    );

    adr_rcla #(.WIDTH(9)) dut9 (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x9),
        .y     (y9),
        .cin   (cin9),
        .sum   (sum9),
        .cout  (cout9),
        .ovf   (ovf9)
`ifdef ADR_RCLA_PG_OUT_EN
        ,
        .gp    (gp9),
        .gg    (gg9)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read 1 ns after the
    // rising edge that captured them.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic [2:0] a, input logic [2:0] b, input logic c);
        @(negedge clk);
        x3 = a;
        y3 = b;
        cin3 = c;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive3(3'd7, 3'd7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({sum3, cout3, ovf3} !== 5'b0) begin
                bad++;
                $display("FAIL reset_hold cyc%0d: got sum=%0d cout=%0b ovf=%0b want 0 0 0",
                         i, sum3, cout3, ovf3);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (sum3 !== 3'd7 || cout3 !== 1'b1 || ovf3 !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got sum=%0d cout=%0b ovf=%0b want 7 1 0",
                     sum3, cout3, ovf3);
        end
    endtask

    task automatic test_basic();
        drive3(3'd3, 3'd4, 1'b0);
        step();
        total++;
        if (sum3 !== 3'd7 || cout3 !== 1'b0 || ovf3 !== 1'b0) begin
            bad++;
            $display("FAIL basic_3p4: got sum=%0d cout=%0b ovf=%0b want 7 0 0",
                     sum3, cout3, ovf3);
        end
        drive3(3'd3, 3'd1, 1'b0);
        step();
        total++;
        if (sum3 !== 3'd4 || cout3 !== 1'b0 || ovf3 !== 1'b1) begin
            bad++;
            $display("FAIL basic_ovf: got sum=%0d cout=%0b ovf=%0b want 4 0 1",
                     sum3, cout3, ovf3);
        end
    endtask

    task automatic test_carry();
        drive3(3'd5, 3'd3, 1'b0);
        step();
        total++;
        if (sum3 !== 3'd0 || cout3 !== 1'b1 || ovf3 !== 1'b0) begin
            bad++;
            $display("FAIL carry_5p3: got sum=%0d cout=%0b ovf=%0b want 0 1 0",
                     sum3, cout3, ovf3);
        end
        drive3(3'd0, 3'd0, 1'b1);
        step();
        total++;
        if (sum3 !== 3'd1 || cout3 !== 1'b0 || ovf3 !== 1'b0) begin
            bad++;
            $display("FAIL carry_cin_only: got sum=%0d cout=%0b ovf=%0b want 1 0 0",
                     sum3, cout3, ovf3);
        end
    endtask

    task automatic test_sweep();
        int a;
        int b;
        int c;
        int full;
        int low;
        logic [2:0] es;
        logic ec;
        logic eo;
        for (int n = 0; n < 128; n++) begin
            b = n % 8;
            c = (n / 8) % 2;
            a = n / 16;
            drive3(3'(a), 3'(b), 1'(c));
            step();
            full = a + b + c;
            low  = (a % 4) + (b % 4) + c;
            es = 3'(full);
            ec = 1'(full / 8);
            eo = ec ^ 1'(low / 4);
            total++;
            if (sum3 !== es || cout3 !== ec || ovf3 !== eo) begin
                bad++;
                $display("FAIL sweep %0d+%0d+%0d: got sum=%0d cout=%0b ovf=%0b want %0d %0b %0b",
                         a, b, c, sum3, cout3, ovf3, es, ec, eo);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive3(3'd6, 3'd6, 1'b1);
        step();
        drive3(3'd1, 3'd1, 1'b0);
        total++;
        if (sum3 !== 3'd5 || cout3 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: got sum=%0d cout=%0b want 5 1", sum3, cout3);
        end
        step();
        total++;
        if (sum3 !== 3'd2 || cout3 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: got sum=%0d cout=%0b want 2 0", sum3, cout3);
        end
    endtask

    task automatic test_async_reset();
        drive3(3'd7, 3'd7, 1'b1);
        x9 = 9'h1FF;
        y9 = 9'h1FF;
        cin9 = 1'b1;
        step();
        total++;
        if (sum3 !== 3'd7 || cout3 !== 1'b1 || sum9 !== 9'h1FF || cout9 !== 1'b1) begin
            bad++;
            $display("FAIL async_pre: got sum3=%0d cout3=%0b sum9=%0h cout9=%0b want 7 1 1ff 1",
                     sum3, cout3, sum9, cout9);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({sum3, cout3, ovf3} !== 5'b0 || {sum9, cout9, ovf9} !== 11'b0) begin
            bad++;
            $display("FAIL async_drop: got sum3=%0d cout3=%0b sum9=%0h cout9=%0b want all 0",
                     sum3, cout3, sum9, cout9);
        end
        @(negedge clk);
        x3 = 3'd2;
        y3 = 3'd3;
        cin3 = 1'b1;
        rst_n = 1'b1;
        step();
        total++;
        if (sum3 !== 3'd6 || cout3 !== 1'b0) begin
            bad++;
            $display("FAIL async_recover: got sum=%0d cout=%0b want 6 0", sum3, cout3);
        end
    endtask

    task automatic test_width9();
        logic [8:0] xv [4];
        logic [8:0] yv [4];
        logic       cv [4];
        logic [8:0] es [4];
        logic       ec [4];
        logic       eo [4];
        xv[0] = 9'h1FF; yv[0] = 9'h000; cv[0] = 1'b1; es[0] = 9'h000; ec[0] = 1'b1; eo[0] = 1'b0;
        xv[1] = 9'h100; yv[1] = 9'h100; cv[1] = 1'b0; es[1] = 9'h000; ec[1] = 1'b1; eo[1] = 1'b1;
        xv[2] = 9'h0AB; yv[2] = 9'h155; cv[2] = 1'b1; es[2] = 9'h001; ec[2] = 1'b1; eo[2] = 1'b0;
        xv[3] = 9'h00F; yv[3] = 9'h0F1; cv[3] = 1'b0; es[3] = 9'h100; ec[3] = 1'b0; eo[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x9 = xv[i];
            y9 = yv[i];
            cin9 = cv[i];
            step();
            total++;
            if (sum9 !== es[i] || cout9 !== ec[i] || ovf9 !== eo[i]) begin
                bad++;
                $display("FAIL w9_vec%0d: got sum=%0h cout=%0b ovf=%0b want %0h %0b %0b",
                         i, sum9, cout9, ovf9, es[i], ec[i], eo[i]);
            end
        end
    endtask

`ifdef ADR_RCLA_PG_OUT_EN
    task automatic test_pg_out();
        @(negedge clk);
        x9 = 9'h1FF;
        y9 = 9'h000;
        cin9 = 1'b1;
        step();
        total++;
        if (gp9 !== 1'b1 || gg9 !== 1'b0) begin
            bad++;
            $display("FAIL pg_allprop: got gp=%0b gg=%0b want 1 0", gp9, gg9);
        end
        @(negedge clk);
        x9 = 9'h100;
        y9 = 9'h100;
        cin9 = 1'b0;
        step();
        total++;
        if (gp9 !== 1'b0 || gg9 !== 1'b1) begin
            bad++;
            $display("FAIL pg_gen: got gp=%0b gg=%0b want 0 1", gp9, gg9);
        end
        @(negedge clk);
        x9 = 9'h0FF;
        y9 = 9'h001;
        cin9 = 1'b1;
        step();
        total++;
        if (gp9 !== 1'b0 || gg9 !== 1'b0) begin
            bad++;
            $display("FAIL pg_none: got gp=%0b gg=%0b want 0 0", gp9, gg9);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        x3 = '0;
        y3 = '0;
        cin3 = 1'b0;
        x9 = '0;
        y9 = '0;
        cin9 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_sweep();
        test_back_to_back();
        test_async_reset();
        test_width9();
`ifdef ADR_RCLA_PG_OUT_EN
        test_pg_out();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
